// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// The queue takes the slave modport and the fetch/decode side takes the master modport.
interface fetch_decode_queue_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               fetch_valid_i;
    logic [ADDR_W-1:0]  fetch_pc_i;
    logic [INSTR_W-1:0] fetch_instr_i;
    logic               fetch_ready_o;
    logic               dec_ready_i;
    logic               dec_valid_o;
    logic [ADDR_W-1:0]  dec_pc_o;
    logic [INSTR_W-1:0] dec_instr_o;
    logic [6:0]         dec_op_o;
    logic [2:0]         dec_func3_o;
    logic               dec_func7_5_o;
    logic               dec_instr_25_o;

    modport master (
        output fetch_valid_i, fetch_pc_i, fetch_instr_i, dec_ready_i,
        input  fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o,
        input  dec_op_o, dec_func3_o, dec_func7_5_o, dec_instr_25_o
    );

    modport slave (
        input  fetch_valid_i, fetch_pc_i, fetch_instr_i, dec_ready_i,
        output fetch_ready_o, dec_valid_o, dec_pc_o, dec_instr_o,
        output dec_op_o, dec_func3_o, dec_func7_5_o, dec_instr_25_o
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Show-ahead instruction FIFO between fetch and decode.
// Presents the head entry and its decoder fields; a flush drops every entry.
module fetch_decode_queue #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 64,
    parameter int          INSTR_W   = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    localparam int         PW        = $clog2(DEPTH),
    localparam int         CW        = PW + 1
) (
    input  logic            clk_i,
    input  logic            arst_ni,
    input  logic            flush_i,
    fetch_decode_queue_if.slave q,
    output logic [CW-1:0]   count_o
);

    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = q.fetch_valid_i & ~w_full;
    assign w_pop   = ~w_empty & q.dec_ready_i;

    assign q.fetch_ready_o = ~w_full;
    assign q.dec_valid_o   = ~w_empty;
    assign count_o         = r_count;

    // Storage holds no reset; validity comes only from the count.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_pc_mem[r_wr_ptr]    <= q.fetch_pc_i;
            r_instr_mem[r_wr_ptr] <= q.fetch_instr_i;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        q.dec_pc_o    = '0;
        q.dec_instr_o = NOP_INSTR;
        if (!w_empty) begin
            q.dec_pc_o    = r_pc_mem[r_rd_ptr];
            q.dec_instr_o = r_instr_mem[r_rd_ptr];
        end
    end

    assign q.dec_op_o       = q.dec_instr_o[6:0];
    assign q.dec_func3_o    = q.dec_instr_o[14:12];
    assign q.dec_func7_5_o  = q.dec_instr_o[30];
    assign q.dec_instr_25_o = q.dec_instr_o[25];

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: ordering, stall, wrap,
// flush, field extraction and asynchronous reset.
module tb_fetch_decode_queue;

    logic       clk_i = 1'b0;
    logic       arst_ni;
    logic       flush_i;
    logic [2:0] count_o;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_decode_queue_if #(.ADDR_W(64), .INSTR_W(32)) q ();

    fetch_decode_queue #(
        .DEPTH(4), .ADDR_W(64), .INSTR_W(32), .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .flush_i (flush_i),
        .q       (q.slave),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc,
                         input logic [31:0] ins, input logic rdy);
        q.fetch_valid_i = v;
        q.fetch_pc_i    = pc;
        q.fetch_instr_i = ins;
        q.dec_ready_i   = rdy;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".cnt"}, 64'(count_o), 64'd0);
        chk({tag, ".vld"}, 64'(q.dec_valid_o), 64'd0);
        chk({tag, ".pc"}, q.dec_pc_o, 64'd0);
        chk({tag, ".ins"}, 64'(q.dec_instr_o), 64'h13);
    endtask

    initial begin
        arst_ni = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, 64'd0, 32'd0, 1'b0);
        #12;
        chk_empty("rst");
        chk("rst.op", 64'(q.dec_op_o), 64'h13);
        chk("rst.f3", 64'(q.dec_func3_o), 64'd0);
        chk("rst.f75", 64'(q.dec_func7_5_o), 64'd0);
        chk("rst.b25", 64'(q.dec_instr_25_o), 64'd0);
        chk("rst.rdy", 64'(q.fetch_ready_o), 64'd1);
        @(negedge clk_i);
        arst_ni = 1'b1;
        tick();

        // single push, immediate consume
        drive(1'b1, 64'h1000, 32'h00A0_0093, 1'b1);
        tick();
        drive(1'b0, 64'd0, 32'd0, 1'b1);
        chk("one.vld", 64'(q.dec_valid_o), 64'd1);
        chk("one.pc", q.dec_pc_o, 64'h1000);
        chk("one.op", 64'(q.dec_op_o), 64'h13);
        chk("one.f3", 64'(q.dec_func3_o), 64'd0);
        tick();
        chk_empty("one.after");

        // fill while stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h1000 + 64'(4 * i), 32'h0000_0013, 1'b0);
            tick();
            chk("fill.head", q.dec_pc_o, 64'h1000);
        end
        chk("fill.cnt", 64'(count_o), 64'd4);
        chk("fill.rdy", 64'(q.fetch_ready_o), 64'd0);
        drive(1'b1, 64'h1010, 32'h0000_0013, 1'b0);
        tick();
        chk("over.cnt", 64'(count_o), 64'd4);
        chk("over.head", q.dec_pc_o, 64'h1000);
        // a pop in the full cycle must not let a push through
        drive(1'b1, 64'h1010, 32'h0000_0013, 1'b1);
        chk("drain.pc0", q.dec_pc_o, 64'h1000);
        tick();
        chk("drain.cnt3", 64'(count_o), 64'd3);
        drive(1'b0, 64'd0, 32'd0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            chk("drain.pc", q.dec_pc_o, 64'h1000 + 64'(4 * i));
            tick();
        end
        chk_empty("drain.end");

        // preload two entries, then simultaneous push/pop across wrap
        drive(1'b1, 64'h2000, 32'h0000_0013, 1'b0);
        tick();
        drive(1'b1, 64'h2004, 32'h0000_0013, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h2008 + 64'(4 * i), 32'h0000_0013, 1'b1);
            chk("wrap.pc", q.dec_pc_o, 64'h2000 + 64'(4 * i));
            tick();
            chk("wrap.cnt", 64'(count_o), 64'd2);
        end

        // bring to three entries, then flush with push and pop
        drive(1'b1, 64'h2030, 32'h0000_0013, 1'b0);
        tick();
        chk("pre.cnt", 64'(count_o), 64'd3);
        drive(1'b1, 64'h2034, 32'h0000_0013, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, 64'd0, 32'd0, 1'b1);
        chk_empty("flush");
        tick();
        chk_empty("flush.after");

        // field extraction
        drive(1'b1, 64'h3000, 32'h40B5_0533, 1'b0);
        tick();
        drive(1'b1, 64'h3004, 32'h02B5_0533, 1'b0);
        tick();
        chk("sub.op", 64'(q.dec_op_o), 64'h33);
        chk("sub.f3", 64'(q.dec_func3_o), 64'd0);
        chk("sub.f75", 64'(q.dec_func7_5_o), 64'd1);
        chk("sub.b25", 64'(q.dec_instr_25_o), 64'd0);
        drive(1'b0, 64'd0, 32'd0, 1'b1);
        tick();
        chk("mul.pc", q.dec_pc_o, 64'h3004);
        chk("mul.b25", 64'(q.dec_instr_25_o), 64'd1);
        chk("mul.f75", 64'(q.dec_func7_5_o), 64'd0);
        tick();
        chk_empty("fld.end");

        // asynchronous reset between edges
        drive(1'b1, 64'h4000, 32'h0000_0013, 1'b0);
        tick();
        drive(1'b1, 64'h4004, 32'h0000_0013, 1'b0);
        tick();
        drive(1'b0, 64'd0, 32'd0, 1'b0);
        chk("ar.cnt2", 64'(count_o), 64'd2);
        #2;
        arst_ni = 1'b0;
        #1;
        chk_empty("ar");
        chk("ar.rdy", 64'(q.fetch_ready_o), 64'd1);
        @(negedge clk_i);
        arst_ni = 1'b1;
        tick();
        chk_empty("ar.after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Small instruction FIFO between the fetch stage and the decode stage.
- Buffers (pc, instruction) pairs from fetch and presents the head entry to decode.
- Splits the head instruction into the fields the control decoder consumes: opcode, func3, func7[5] and bit 25.
- Absorbs short decode stalls without stalling fetch, and discards all contents on a pipeline flush (branch/jump redirect, trap).

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, at least 2.
- ADDR_W, 64, PC width.
- INSTR_W, 32, instruction width; fixed at 32 (RV base encoding).
- NOP_INSTR, 32'h00000013, instruction presented to decode when the queue is empty (addi x0,x0,0).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- arst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  discard all entries; has priority over push and pop.
- fetch_valid_i  input  1  fetch presents a valid entry.
- fetch_pc_i  input  ADDR_W  PC of the pushed instruction.
- fetch_instr_i  input  INSTR_W  pushed instruction word.
- fetch_ready_o  output  1  queue accepts a push this cycle.
- dec_ready_i  input  1  decode consumes the head this cycle (low = stall).
- dec_valid_o  output  1  head entry valid.
- dec_pc_o  output  ADDR_W  head PC; 0 when empty.
- dec_instr_o  output  INSTR_W  head instruction; NOP_INSTR when empty.
- dec_op_o  output  7  dec_instr_o[6:0].
- dec_func3_o  output  3  dec_instr_o[14:12].
- dec_func7_5_o  output  1  dec_instr_o[30].
- dec_instr_25_o  output  1  dec_instr_o[25].
- count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
Reset (arst_ni low, asynchronous):
- Read pointer, write pointer and count go to 0.
- Outputs: dec_valid_o=0, dec_pc_o=0, dec_instr_o=NOP_INSTR (so dec_op_o=7'h13, dec_func3_o=0, dec_func7_5_o=0, dec_instr_25_o=0), count_o=0, fetch_ready_o=1.
- Storage array contents are not reset.
- Reset asserted mid-operation drops all entries immediately; no partial push or pop completes.

Handshake rules:
- push = fetch_valid_i & fetch_ready_o.
- pop = dec_valid_o & dec_ready_i.
- fetch_ready_o = (count_o != DEPTH). There is no pass-through when full: a simultaneous pop in the full cycle does not enable a push.
- dec_valid_o = (count_o != 0).
- Head outputs are combinational from storage[rd_ptr] (show-ahead).
- Field outputs are combinational slices of dec_instr_o.

Latency and pointers:
- Minimum push-to-visible latency is 1 cycle. There is no empty bypass: an entry pushed in cycle N appears on dec_* in cycle N+1.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Order is strict FIFO.

Count update each edge:
- flush_i: count=0, rd_ptr=wr_ptr=0. Push and pop in the same cycle are ignored, and the pushed entry is discarded.
- push & pop: count unchanged, both pointers advance.
- push only: count+1, wr_ptr advances, entry written.
- pop only: count-1, rd_ptr advances.
- Neither: hold.

Constraints and boundaries:
- While stalled (dec_ready_i=0), the head is stable. dec_pc_o and dec_instr_o must not change until the pop is taken.
- Empty with pop requested: no effect, because dec_valid_o=0.
- The block is purely a buffer and does not decode legality.

Test Plan:
1. Reset then idle: count_o=0, dec_valid_o=0, dec_instr_o=32'h00000013, dec_op_o=7'h13, fetch_ready_o=1.
2. Single push of pc=0x1000, instr=0x00A00093 (addi x1,x0,10) with dec_ready_i=1:
   - Next cycle: dec_valid_o=1, dec_pc_o=0x1000, dec_op_o=0x13, dec_func3_o=0.
   - Cycle after: empty again.
3. Fill while stalled: push pcs 0x1000, 0x1004, 0x1008, 0x100C with dec_ready_i=0.
   - count_o=4, fetch_ready_o=0.
   - A fifth push at 0x1010 is not accepted.
   - Head stays 0x1000 throughout.
   - Release the stall: the pops emerge in order 0x1000..0x100C.
4. Wrap-around: run 10 push/pop cycles at the same time with sequential pcs.
   - count_o stays constant.
   - Output pc sequence is exactly the input sequence delayed by the occupancy, across pointer wrap.
5. Flush with simultaneous push and pop at count=3: next cycle count_o=0, dec_valid_o=0, and the pushed entry does not appear.
6. Field extraction: push instr=0x40B50533 (sub x10,x10,x11) -> dec_op_o=7'h33, dec_func3_o=0, dec_func7_5_o=1, dec_instr_25_o=0. Then push 0x02B50533 (mul) -> dec_instr_25_o=1, dec_func7_5_o=0.
7. Reset mid-operation: assert arst_ni low asynchronously with count=2 between edges -> outputs return to reset values without waiting for a clock edge.
